// File: rtl/mem_port_arbiter.sv
// Shares one in-order memory port between the iBus and dBus: round-robin command
// arbitration with a lock while the port stalls, plus a FIFO that routes read responses.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ibus_cmd_valid,
  output logic                       ibus_cmd_ready,
  input  logic [ADDR_W-1:0]          ibus_cmd_address,
  input  logic [ID_W-1:0]            ibus_cmd_id,
  output logic                       ibus_rsp_valid,
  output logic [DATA_W-1:0]          ibus_rsp_data,
  output logic [ADDR_W-1:0]          ibus_rsp_address,
  output logic [ID_W-1:0]            ibus_rsp_id,
  input  logic                       dbus_cmd_valid,
  output logic                       dbus_cmd_ready,
  input  logic [ADDR_W-1:0]          dbus_cmd_address,
  input  logic [DATA_W-1:0]          dbus_cmd_data,
  input  logic [DATA_W/8-1:0]        dbus_cmd_mask,
  input  logic                       dbus_cmd_write,
  input  logic [ID_W-1:0]            dbus_cmd_id,
  output logic                       dbus_rsp_valid,
  output logic [DATA_W-1:0]          dbus_rsp_data,
  output logic [ID_W-1:0]            dbus_rsp_id,
  output logic                       mem_cmd_valid,
  input  logic                       mem_cmd_ready,
  output logic [ADDR_W-1:0]          mem_cmd_address,
  output logic [DATA_W-1:0]          mem_cmd_data,
  output logic [DATA_W/8-1:0]        mem_cmd_mask,
  output logic                       mem_cmd_write,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_W-1:0]          mem_rsp_data,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       err_unexpected_rsp
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  // src: 0 = iBus, 1 = dBus
  typedef struct packed {
    logic              src;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
  } trk_t;

  state_t          state;
  logic            rr_d;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wptr, rptr;
  trk_t            fifo_q [DEPTH];
  trk_t            head;

  logic rd_ok, i_elig, d_elig, sel_i, sel_d, acc_i, acc_d, push, pop;

  // Slot availability uses the registered count only; a same-cycle pop frees nothing.
  assign rd_ok  = count < CW'(DEPTH);
  assign i_elig = ibus_cmd_valid & rd_ok;
  assign d_elig = dbus_cmd_valid & (dbus_cmd_write | rd_ok);

  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          sel_d = d_elig & (rr_d | ~i_elig);
          sel_i = i_elig & ~sel_d;
        end
        LOCK_I:  sel_i = ibus_cmd_valid;
        LOCK_D:  sel_d = dbus_cmd_valid;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_cmd_address = ibus_cmd_address;
    mem_cmd_data    = '0;
    mem_cmd_mask    = '1;
    mem_cmd_write   = 1'b0;
    if (sel_d) begin
      mem_cmd_address = dbus_cmd_address;
      mem_cmd_data    = dbus_cmd_data;
      mem_cmd_mask    = dbus_cmd_mask;
      mem_cmd_write   = dbus_cmd_write;
    end
  end

  assign mem_cmd_valid  = sel_i | sel_d;
  assign acc_i          = sel_i & mem_cmd_ready;
  assign acc_d          = sel_d & mem_cmd_ready;
  assign ibus_cmd_ready = acc_i;
  assign dbus_cmd_ready = acc_d;
  assign push           = acc_i | (acc_d & ~dbus_cmd_write);

  assign head             = fifo_q[rptr];
  assign pop              = ~reset & mem_rsp_valid & (count != '0);
  assign ibus_rsp_valid   = pop & ~head.src;
  assign dbus_rsp_valid   = pop & head.src;
  assign ibus_rsp_data    = mem_rsp_data;
  assign dbus_rsp_data    = mem_rsp_data;
  assign ibus_rsp_id      = head.id;
  assign dbus_rsp_id      = head.id;
  assign ibus_rsp_address = head.addr;
  assign outstanding      = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      rr_d               <= 1'b1;
      count              <= '0;
      wptr               <= '0;
      rptr               <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_i && !mem_cmd_ready)      state <= LOCK_I;
          else if (sel_d && !mem_cmd_ready) state <= LOCK_D;
        end
        LOCK_I:  if (!ibus_cmd_valid || mem_cmd_ready) state <= IDLE;
        LOCK_D:  if (!dbus_cmd_valid || mem_cmd_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (acc_i || acc_d) rr_d <= acc_i;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (mem_rsp_valid && count == '0) err_unexpected_rsp <= 1'b1;
    end
  end

  // Tracking payload needs no reset; the pointers define what is live.
  always_ff @(posedge clock) begin
    if (push) fifo_q[wptr] <= '{src: acc_d, id: (acc_d ? dbus_cmd_id : ibus_cmd_id),
                                addr: (acc_d ? dbus_cmd_address : ibus_cmd_address)};
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants checked cycle by cycle, read
// responses checked against a scoreboard filled when each read is accepted.
module tb_mem_port_arbiter;
  logic        clock, reset;
  logic        ibus_cmd_valid, ibus_cmd_ready;
  logic [63:0] ibus_cmd_address;
  logic [15:0] ibus_cmd_id;
  logic        ibus_rsp_valid;
  logic [63:0] ibus_rsp_data, ibus_rsp_address;
  logic [15:0] ibus_rsp_id;
  logic        dbus_cmd_valid, dbus_cmd_ready;
  logic [63:0] dbus_cmd_address, dbus_cmd_data;
  logic [7:0]  dbus_cmd_mask;
  logic        dbus_cmd_write;
  logic [15:0] dbus_cmd_id;
  logic        dbus_rsp_valid;
  logic [63:0] dbus_rsp_data;
  logic [15:0] dbus_rsp_id;
  logic        mem_cmd_valid, mem_cmd_ready;
  logic [63:0] mem_cmd_address, mem_cmd_data;
  logic [7:0]  mem_cmd_mask;
  logic        mem_cmd_write;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [2:0]  outstanding;
  logic        err_unexpected_rsp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          src;
    logic [15:0] id;
    logic [63:0] addr;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
    .ibus_cmd_address(ibus_cmd_address), .ibus_cmd_id(ibus_cmd_id),
    .ibus_rsp_valid(ibus_rsp_valid), .ibus_rsp_data(ibus_rsp_data),
    .ibus_rsp_address(ibus_rsp_address), .ibus_rsp_id(ibus_rsp_id),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
    .dbus_cmd_address(dbus_cmd_address), .dbus_cmd_data(dbus_cmd_data),
    .dbus_cmd_mask(dbus_cmd_mask), .dbus_cmd_write(dbus_cmd_write),
    .dbus_cmd_id(dbus_cmd_id),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rsp_data(dbus_rsp_data),
    .dbus_rsp_id(dbus_rsp_id),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_address(mem_cmd_address), .mem_cmd_data(mem_cmd_data),
    .mem_cmd_mask(mem_cmd_mask), .mem_cmd_write(mem_cmd_write),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input bit src, input logic [15:0] id, input logic [63:0] addr,
                          input logic [63:0] data);
    exp_t x;
    x.src = src; x.id = id; x.addr = addr; x.data = data;
    exp_q.push_back(x);
  endtask

  task automatic respond(input bit src, input logic [63:0] d);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    #1;
    chk(src ? "dbus_rsp_valid" : "ibus_rsp_valid", src ? dbus_rsp_valid : ibus_rsp_valid, 1);
  endtask

  task automatic drive_i(input logic v, input logic [15:0] id, input logic [63:0] a);
    ibus_cmd_valid = v; ibus_cmd_id = id; ibus_cmd_address = a;
  endtask

  task automatic drive_d(input logic v, input logic w, input logic [15:0] id,
                         input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    dbus_cmd_valid = v; dbus_cmd_write = w; dbus_cmd_id = id;
    dbus_cmd_address = a; dbus_cmd_data = d; dbus_cmd_mask = m;
  endtask

  // Response monitor: every routed response must match the oldest accepted read.
  always @(negedge clock) begin
    if (!reset && (ibus_rsp_valid || dbus_rsp_valid)) begin
      chk("rsp_one_bus", {63'd0, ibus_rsp_valid & dbus_rsp_valid}, 0);
      chk("rsp_expected", {63'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_src", {63'd0, dbus_rsp_valid}, {63'd0, e.src});
        if (e.src) begin
          chk("dbus_rsp_id", dbus_rsp_id, e.id);
          chk("dbus_rsp_data", dbus_rsp_data, e.data);
        end else begin
          chk("ibus_rsp_id", ibus_rsp_id, e.id);
          chk("ibus_rsp_data", ibus_rsp_data, e.data);
          chk("ibus_rsp_address", ibus_rsp_address, e.addr);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive_i(1, 16'h1, 64'h100);
    drive_d(1, 0, 16'h2, 64'h200, 64'h0, 8'hFF);
    mem_cmd_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0;
    step();
    chk("rst_mem_cmd_valid", mem_cmd_valid, 0);
    chk("rst_ibus_cmd_ready", ibus_cmd_ready, 0);
    chk("rst_dbus_cmd_ready", dbus_cmd_ready, 0);
    chk("rst_rsp_valid", {ibus_rsp_valid, dbus_rsp_valid}, 0);
    step();
    reset = 1'b0;
    drive_i(0, 0, 0); drive_d(0, 0, 0, 0, 0, 0); mem_rsp_valid = 1'b0;
    #1;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unexpected_rsp, 0);

    // single fetch round trip
    drive_i(1, 16'd5, 64'h1000);
    #1;
    chk("t1_mem_cmd_valid", mem_cmd_valid, 1);
    chk("t1_mem_cmd_address", mem_cmd_address, 64'h1000);
    chk("t1_mem_cmd_write", mem_cmd_write, 0);
    chk("t1_mem_cmd_mask", mem_cmd_mask, 8'hFF);
    chk("t1_mem_cmd_data", mem_cmd_data, 0);
    chk("t1_ibus_cmd_ready", ibus_cmd_ready, 1);
    chk("t1_dbus_cmd_ready", dbus_cmd_ready, 0);
    push_exp(0, 16'd5, 64'h1000, 64'hDEAD);
    step();
    drive_i(0, 0, 0);
    chk("t1_outstanding_1", outstanding, 1);
    respond(0, 64'hDEAD);
    step();
    mem_rsp_valid = 1'b0; #1;
    chk("t1_outstanding_0", outstanding, 0);

    // both request every cycle: D, I, D, I
    drive_i(1, 16'd3, 64'h3000);
    drive_d(1, 0, 16'd7, 64'h2000, 0, 8'hFF);
    #1;
    chk("t2_g1_dbus", dbus_cmd_ready, 1);
    chk("t2_g1_ibus", ibus_cmd_ready, 0);
    chk("t2_g1_addr", mem_cmd_address, 64'h2000);
    push_exp(1, 16'd7, 64'h2000, 64'h7777);
    step();
    drive_d(1, 0, 16'd8, 64'h2008, 0, 8'hFF);
    #1;
    chk("t2_g2_ibus", ibus_cmd_ready, 1);
    chk("t2_g2_dbus", dbus_cmd_ready, 0);
    chk("t2_g2_addr", mem_cmd_address, 64'h3000);
    push_exp(0, 16'd3, 64'h3000, 64'h3333);
    step();
    drive_i(1, 16'd4, 64'h3008);
    #1;
    chk("t2_g3_dbus", dbus_cmd_ready, 1);
    chk("t2_g3_addr", mem_cmd_address, 64'h2008);
    push_exp(1, 16'd8, 64'h2008, 64'h8888);
    step();
    drive_d(1, 0, 16'd13, 64'h2010, 0, 8'hFF);
    #1;
    chk("t2_g4_ibus", ibus_cmd_ready, 1);
    chk("t2_g4_addr", mem_cmd_address, 64'h3008);
    push_exp(0, 16'd4, 64'h3008, 64'h4444);
    step();

    // FIFO full: reads blocked, store still passes
    drive_i(1, 16'd5, 64'h4000);
    drive_d(1, 1, 16'd9, 64'h5000, 64'h1122334455667788, 8'h0F);
    #1;
    chk("t4_full_count", outstanding, 4);
    chk("t4_store_ready", dbus_cmd_ready, 1);
    chk("t4_read_blocked", ibus_cmd_ready, 0);
    chk("t4_store_write", mem_cmd_write, 1);
    chk("t4_store_mask", mem_cmd_mask, 8'h0F);
    chk("t4_store_addr", mem_cmd_address, 64'h5000);
    chk("t4_store_data", mem_cmd_data, 64'h1122334455667788);
    step();
    drive_d(0, 0, 0, 0, 0, 0);
    respond(1, 64'h7777);
    chk("t4_pop_no_free", ibus_cmd_ready, 0);
    chk("t4_no_cmd", mem_cmd_valid, 0);
    step();
    mem_rsp_valid = 1'b0; #1;
    chk("t4_count_3", outstanding, 3);
    chk("t4_read_after_free", ibus_cmd_ready, 1);
    push_exp(0, 16'd5, 64'h4000, 64'h5555);
    step();
    drive_i(0, 0, 0);
    chk("t5_full_again", outstanding, 4);
    respond(0, 64'h3333);
    step();
    drive_i(1, 16'd10, 64'h6000);
    respond(1, 64'h8888);
    chk("t5_pushpop_ready", ibus_cmd_ready, 1);
    push_exp(0, 16'd10, 64'h6000, 64'hAAAA);
    step();
    drive_i(0, 0, 0); mem_rsp_valid = 1'b0; #1;
    chk("t5_pushpop_count", outstanding, 3);
    respond(0, 64'h4444); step();
    respond(0, 64'h5555); step();
    respond(0, 64'hAAAA); step();
    mem_rsp_valid = 1'b0; #1;
    chk("t5_drained", outstanding, 0);

    // iBus locked while the port stalls; RR favours dBus throughout
    mem_cmd_ready = 1'b0;
    drive_i(1, 16'd11, 64'h7000);
    #1;
    chk("t3_c1_addr", mem_cmd_address, 64'h7000);
    chk("t3_c1_ready", ibus_cmd_ready, 0);
    step();
    drive_d(1, 0, 16'd12, 64'h7100, 0, 8'hFF);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t3_lock_addr", mem_cmd_address, 64'h7000);
      chk("t3_lock_valid", mem_cmd_valid, 1);
      chk("t3_lock_dbus", dbus_cmd_ready, 0);
      step();
    end
    mem_cmd_ready = 1'b1; #1;
    chk("t3_i_accept", ibus_cmd_ready, 1);
    chk("t3_i_addr", mem_cmd_address, 64'h7000);
    push_exp(0, 16'd11, 64'h7000, 64'h1111);
    step();
    drive_i(1, 16'd14, 64'h7008);
    #1;
    chk("t3_d_next", dbus_cmd_ready, 1);
    chk("t3_i_wait", ibus_cmd_ready, 0);
    chk("t3_d_addr", mem_cmd_address, 64'h7100);
    push_exp(1, 16'd12, 64'h7100, 64'h1212);
    step();
    drive_i(0, 0, 0); drive_d(0, 0, 0, 0, 0, 0);
    respond(0, 64'h1111); step();
    respond(1, 64'h1212); step();
    mem_rsp_valid = 1'b0;

    // unexpected response
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hBAD; #1;
    chk("t6_no_rsp", {ibus_rsp_valid, dbus_rsp_valid}, 0);
    step();
    mem_rsp_valid = 1'b0; #1;
    chk("t6_err_set", err_unexpected_rsp, 1);
    step();
    chk("t6_err_held", err_unexpected_rsp, 1);

    // reset while locked on a dBus store, with one read in flight
    drive_i(1, 16'd16, 64'h9000); #1;
    chk("t7_read_acc", ibus_cmd_ready, 1);
    step();
    drive_i(0, 0, 0);
    mem_cmd_ready = 1'b0;
    drive_d(1, 1, 16'd15, 64'h8000, 64'h55, 8'hF0);
    step();
    chk("t7_lockd_valid", mem_cmd_valid, 1);
    chk("t7_lockd_write", mem_cmd_write, 1);
    chk("t7_outstanding", outstanding, 1);
    reset = 1'b1; mem_cmd_ready = 1'b1; #1;
    chk("t7_rst_cmd_valid", mem_cmd_valid, 0);
    chk("t7_rst_dbus_ready", dbus_cmd_ready, 0);
    step();
    reset = 1'b0;
    drive_i(1, 16'd17, 64'hA000);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h99; #1;
    chk("t7_post_outstanding", outstanding, 0);
    chk("t7_post_err", err_unexpected_rsp, 0);
    chk("t7_discarded_rsp", ibus_rsp_valid, 0);
    chk("t7_rr_favours_d", dbus_cmd_ready, 1);
    chk("t7_rr_i_waits", ibus_cmd_ready, 0);
    step();
    drive_i(0, 0, 0); drive_d(0, 0, 0, 0, 0, 0); mem_rsp_valid = 1'b0; #1;
    chk("t7_err_after", err_unexpected_rsp, 1);
    chk("t7_store_no_push", outstanding, 0);
    step();

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
